// File: rtl/synth_note_recorder_pkg.sv
// Shared definitions for the synth note-word format and the recorder FSM.
// Contents: note-word field positions, terminator word, divider sizing,
// recorder state encoding and a helper that packs a note word.
package synth_note_recorder_pkg;

  // Note word: [28]melody [27:24]inst [23:17]vol [16:10]pitch
  //            [9]stop [8]dacapo [7:0]duration (beats:sixteenths)
  localparam int unsigned MELODY_BIT = 28;
  localparam int unsigned INST_LSB   = 24;
  localparam int unsigned INST_W     = 4;
  localparam int unsigned VOL_LSB    = 17;
  localparam int unsigned VOL_W      = 7;
  localparam int unsigned PITCH_LSB  = 10;
  localparam int unsigned PITCH_W    = 7;
  localparam int unsigned STOP_BIT   = 9;
  localparam int unsigned DACAPO_BIT = 8;
  localparam int unsigned DUR_LSB    = 0;
  localparam int unsigned DUR_W      = 8;

  localparam logic [31:0] TERMINATOR_WORD = 32'h0000_0200;

  localparam int unsigned DIVIDEND_W = 36;
  localparam int unsigned DIVISOR_W  = 23;
  localparam int unsigned DIV_STEPS  = 36;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_DIV   = 3'd2,
    S_WRITE = 3'd3,
    S_FLUSH = 3'd4,
    S_TERM  = 3'd5
  } rec_state_e;

  function automatic logic [31:0] encode_note(
    input logic         melody,
    input logic [3:0]   inst,
    input logic [6:0]   vol,
    input logic [6:0]   pitch,
    input logic [7:0]   dur
  );
    logic [31:0] w;
    w = '0;
    w[MELODY_BIT]               = melody;
    w[INST_LSB  +: INST_W]      = inst;
    w[VOL_LSB   +: VOL_W]       = vol;
    w[PITCH_LSB +: PITCH_W]     = pitch;
    w[STOP_BIT]                 = 1'b0;
    w[DACAPO_BIT]               = 1'b0;
    w[DUR_LSB   +: DUR_W]       = dur;
    return w;
  endfunction

endpackage

// File: rtl/note_duration_divider.sv
// Restoring divider converting a held-note tick count into a duration field.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   start_i            one-cycle pulse loading dividend/divisor
//   dividend_i [35:0]  ticks * 16
//   divisor_i  [22:0]  tempo * ticks-per-ms
//   busy_o             division in progress
//   done_o             one-cycle pulse when quotient_o is valid
//   quotient_o [7:0]   quotient, saturated to 8'hFF (also for divisor 0)
module note_duration_divider
  import synth_note_recorder_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            quotient_o
);

  logic [DIVISOR_W-1:0]  rem_q,  rem_d;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  dvsr_q;
  logic [5:0]            cnt_q;
  logic                  busy_q, done_q, zero_q;
  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W+1:0]  trial;
  logic                  qbit;

  // quo_q starts as the dividend and shifts quotient bits in from the right
  always_comb begin
    rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
    trial     = {1'b0, rem_shift} - {2'b00, dvsr_q};
    qbit      = ~trial[DIVISOR_W+1];
    rem_d     = qbit ? trial[DIVISOR_W-1:0] : rem_shift[DIVISOR_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= '0;
        quo_q  <= dividend_i;
        dvsr_q <= divisor_i;
        cnt_q  <= 6'(DIV_STEPS);
        busy_q <= 1'b1;
        zero_q <= (divisor_i == '0);
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= {quo_q[DIVIDEND_W-2:0], qbit};
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = (zero_q || (|quo_q[DIVIDEND_W-1:8])) ? 8'hFF : quo_q[7:0];

endmodule

// File: rtl/synth_note_recorder.sv
// Records live note-on/note-off events as synth note words in memory.
// Ports:
//   CLK, Reset_n                 clock, async active-low reset
//   iSampleTick                  one strobe per audio sample
//   iStart / iStop               begin recording / flush and terminate
//   iBaseAddr, iTempo            song base address, ms per beat (sampled on iStart)
//   iNoteValid, iNoteOn, iPitch, iVolume, iInst, iMelody   note event
//   oMemWrite, oMemAddress, oMemWriteData, iMemReady       word write handshake
//   oBusy, oWordCount, oOverflow status
//
// state   | meaning
// IDLE    | waiting for iStart
// REC     | tracking held notes, looking for a closed slot to encode
// DIV     | divider converting the chosen slot's tick count
// WRITE   | note word presented, waiting for iMemReady
// FLUSH   | closing all open slots and draining closed ones
// TERM    | terminator word presented, waiting for iMemReady
module synth_note_recorder
  import synth_note_recorder_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 8,
  parameter int unsigned TICKS_PER_MS = 96,
  parameter int unsigned MAX_WORDS    = 1024
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        iSampleTick,
  input  logic        iStart,
  input  logic        iStop,
  input  logic [31:0] iBaseAddr,
  input  logic [15:0] iTempo,
  input  logic        iNoteValid,
  input  logic        iNoteOn,
  input  logic [6:0]  iPitch,
  input  logic [6:0]  iVolume,
  input  logic [3:0]  iInst,
  input  logic        iMelody,
  output logic        oMemWrite,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWriteData,
  input  logic        iMemReady,
  output logic        oBusy,
  output logic [15:0] oWordCount,
  output logic        oOverflow
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

  rec_state_e        state_q;
  logic [31:0]       base_q;
  logic [15:0]       tempo_q;
  logic [15:0]       word_cnt_q;
  logic              ovf_q, stop_pend_q, flush_q, div_start_q;
  logic              mem_write_q;
  logic [31:0]       addr_q, data_q;
  logic [IDX_W-1:0]  wr_idx_q;

  logic [NUM_SLOTS-1:0] slot_valid_q, slot_closed_q;
  logic [31:0]          slot_cnt_q   [NUM_SLOTS];
  logic [6:0]           slot_pitch_q [NUM_SLOTS];
  logic [6:0]           slot_vol_q   [NUM_SLOTS];
  logic [3:0]           slot_inst_q  [NUM_SLOTS];
  logic                 slot_mel_q   [NUM_SLOTS];

  logic             ev_accept, is_on;
  logic             free_found, pitch_open, closed_found, any_open;
  logic [IDX_W-1:0] free_idx, open_idx, closed_idx;
  logic             do_open, do_close, do_drop;
  logic             wr_ack, slot_release, close_all, slot_clear;
  logic             div_busy, div_done;
  logic [7:0]       div_quot;
  logic [DIVISOR_W-1:0] divisor;
  logic [31:0]      next_addr;

  // Descending scan so the lowest matching index wins
  always_comb begin
    ev_accept    = iNoteValid && (state_q == S_REC || state_q == S_DIV || state_q == S_WRITE);
    is_on        = iNoteOn && (iVolume != 7'd0);
    free_found   = 1'b0;
    free_idx     = '0;
    pitch_open   = 1'b0;
    open_idx     = '0;
    closed_found = 1'b0;
    closed_idx   = '0;
    any_open     = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (slot_valid_q[i] && !slot_closed_q[i]) begin
        any_open = 1'b1;
        if (slot_pitch_q[i] == iPitch) begin
          pitch_open = 1'b1;
          open_idx   = IDX_W'(i);
        end
      end
      if (slot_valid_q[i] && slot_closed_q[i]) begin
        closed_found = 1'b1;
        closed_idx   = IDX_W'(i);
      end
    end
    do_open  = ev_accept && is_on && !pitch_open && free_found;
    do_drop  = ev_accept && is_on && !pitch_open && !free_found;
    do_close = ev_accept && !is_on && pitch_open;
  end

  assign wr_ack       = mem_write_q && iMemReady;
  assign slot_release = (state_q == S_WRITE) && wr_ack;
  assign close_all    = (state_q == S_FLUSH);
  assign slot_clear   = (state_q == S_TERM);
  assign divisor      = DIVISOR_W'(tempo_q) * DIVISOR_W'(TICKS_PER_MS);
  assign next_addr    = base_q + {14'd0, word_cnt_q, 2'b00};

  // Tick counting precedes the close so a same-cycle tick still lands in the note
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_valid_q  <= '0;
      slot_closed_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_cnt_q[i]   <= '0;
        slot_pitch_q[i] <= '0;
        slot_vol_q[i]   <= '0;
        slot_inst_q[i]  <= '0;
        slot_mel_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (iSampleTick && slot_valid_q[i] && !slot_closed_q[i] && (slot_cnt_q[i] != 32'hFFFF_FFFF))
          slot_cnt_q[i] <= slot_cnt_q[i] + 32'd1;
        if (slot_clear) begin
          slot_valid_q[i]  <= 1'b0;
          slot_closed_q[i] <= 1'b0;
        end else begin
          if (close_all && slot_valid_q[i])
            slot_closed_q[i] <= 1'b1;
          if (do_close && open_idx == IDX_W'(i))
            slot_closed_q[i] <= 1'b1;
          if (slot_release && wr_idx_q == IDX_W'(i)) begin
            slot_valid_q[i]  <= 1'b0;
            slot_closed_q[i] <= 1'b0;
          end
          if (do_open && free_idx == IDX_W'(i)) begin
            slot_valid_q[i]  <= 1'b1;
            slot_closed_q[i] <= 1'b0;
            slot_cnt_q[i]    <= '0;
            slot_pitch_q[i]  <= iPitch;
            slot_vol_q[i]    <= iVolume;
            slot_inst_q[i]   <= iInst;
            slot_mel_q[i]    <= iMelody;
          end
        end
      end
    end
  end

  note_duration_divider u_div (
    .clk_i      (CLK),
    .rst_ni     (Reset_n),
    .start_i    (div_start_q),
    .dividend_i ({slot_cnt_q[wr_idx_q], 4'b0000}),
    .divisor_i  (divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      tempo_q     <= '0;
      word_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      flush_q     <= 1'b0;
      div_start_q <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_idx_q    <= '0;
    end else begin
      div_start_q <= 1'b0;
      if (do_drop)
        ovf_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            base_q      <= iBaseAddr;
            tempo_q     <= iTempo;
            word_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            state_q     <= S_REC;
          end
        end
        S_REC: begin
          if (word_cnt_q == 16'(MAX_WORDS - 1)) begin
            ovf_q       <= 1'b1;
            mem_write_q <= 1'b1;
            addr_q      <= next_addr;
            data_q      <= TERMINATOR_WORD;
            state_q     <= S_TERM;
          end else if (iStop || stop_pend_q) begin
            stop_pend_q <= 1'b0;
            state_q     <= S_FLUSH;
          end else if (closed_found) begin
            wr_idx_q    <= closed_idx;
            div_start_q <= 1'b1;
            flush_q     <= 1'b0;
            state_q     <= S_DIV;
          end
        end
        S_DIV: begin
          if (iStop)
            stop_pend_q <= 1'b1;
          if (div_done && !div_busy) begin
            mem_write_q <= 1'b1;
            addr_q      <= next_addr;
            data_q      <= encode_note(slot_mel_q[wr_idx_q], slot_inst_q[wr_idx_q],
                                       slot_vol_q[wr_idx_q], slot_pitch_q[wr_idx_q], div_quot);
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (iStop && !flush_q)
            stop_pend_q <= 1'b1;
          if (wr_ack) begin
            mem_write_q <= 1'b0;
            word_cnt_q  <= word_cnt_q + 16'd1;
            state_q     <= flush_q ? S_FLUSH : S_REC;
          end
        end
        S_FLUSH: begin
          // Open slots are closed during this cycle; drain on the following ones
          if (word_cnt_q == 16'(MAX_WORDS - 1)) begin
            ovf_q       <= 1'b1;
            mem_write_q <= 1'b1;
            addr_q      <= next_addr;
            data_q      <= TERMINATOR_WORD;
            state_q     <= S_TERM;
          end else if (any_open) begin
            state_q <= S_FLUSH;
          end else if (closed_found) begin
            wr_idx_q    <= closed_idx;
            div_start_q <= 1'b1;
            flush_q     <= 1'b1;
            state_q     <= S_DIV;
          end else begin
            mem_write_q <= 1'b1;
            addr_q      <= next_addr;
            data_q      <= TERMINATOR_WORD;
            state_q     <= S_TERM;
          end
        end
        S_TERM: begin
          if (wr_ack) begin
            mem_write_q <= 1'b0;
            word_cnt_q  <= word_cnt_q + 16'd1;
            flush_q     <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oMemWrite     = mem_write_q;
  assign oMemAddress   = addr_q;
  assign oMemWriteData = data_q;
  assign oBusy         = (state_q != S_IDLE);
  assign oWordCount    = word_cnt_q;
  assign oOverflow     = ovf_q;

endmodule

// File: tb/tb_synth_note_recorder.sv
module tb_synth_note_recorder;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        iSampleTick, iStart, iStop;
  logic [31:0] iBaseAddr;
  logic [15:0] iTempo;
  logic        iNoteValid, iNoteOn;
  logic [6:0]  iPitch, iVolume;
  logic [3:0]  iInst;
  logic        iMelody;
  logic        oMemWrite;
  logic [31:0] oMemAddress, oMemWriteData;
  logic        iMemReady;
  logic        oBusy;
  logic [15:0] oWordCount;
  logic        oOverflow;

  synth_note_recorder dut (
    .CLK           (CLK),
    .Reset_n       (Reset_n),
    .iSampleTick   (iSampleTick),
    .iStart        (iStart),
    .iStop         (iStop),
    .iBaseAddr     (iBaseAddr),
    .iTempo        (iTempo),
    .iNoteValid    (iNoteValid),
    .iNoteOn       (iNoteOn),
    .iPitch        (iPitch),
    .iVolume       (iVolume),
    .iInst         (iInst),
    .iMelody       (iMelody),
    .oMemWrite     (oMemWrite),
    .oMemAddress   (oMemAddress),
    .oMemWriteData (oMemWriteData),
    .iMemReady     (iMemReady),
    .oBusy         (oBusy),
    .oWordCount    (oWordCount),
    .oOverflow     (oOverflow)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [31:0] cur_base;
  int          exp_idx;
  int          stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] note_word(input logic mel, input logic [3:0] inst,
                                            input logic [6:0] vol, input logic [6:0] pitch,
                                            input longint unsigned ticks, input int unsigned tempo);
    longint unsigned q;
    logic [7:0] d;
    if (tempo == 0) d = 8'hFF;
    else begin
      q = (ticks * 16) / (longint'(tempo) * 96);
      d = (q > 255) ? 8'hFF : 8'(q);
    end
    return (32'(mel) << 28) | (32'(inst) << 24) | (32'(vol) << 17) | (32'(pitch) << 10) | 32'(d);
  endfunction

  task automatic push_exp(input logic [31:0] data);
    wr_t w;
    w.addr = cur_base + 32'(exp_idx * 4);
    w.data = data;
    exp_q.push_back(w);
    exp_idx++;
  endtask

  // Memory responder: optional stall, then accept and compare against the scoreboard
  initial begin
    logic [31:0] held_a, held_d;
    bit          stalling;
    wr_t         w;
    iMemReady = 1'b0;
    stalling  = 1'b0;
    held_a    = '0;
    held_d    = '0;
    forever begin
      @(negedge CLK);
      iMemReady = 1'b0;
      if (Reset_n && oMemWrite) begin
        if (stall_cnt > 0) begin
          if (!stalling) begin
            held_a   = oMemAddress;
            held_d   = oMemWriteData;
            stalling = 1'b1;
          end else begin
            check("stall_write", 64'(oMemWrite), 64'd1);
            check("stall_addr", 64'(oMemAddress), 64'(held_a));
            check("stall_data", 64'(oMemWriteData), 64'(held_d));
          end
          stall_cnt--;
        end else begin
          stalling = 1'b0;
          check("write_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("wr_addr", 64'(oMemAddress), 64'(w.addr));
            check("wr_data", 64'(oMemWriteData), 64'(w.data));
          end
          iMemReady = 1'b1;
        end
      end
    end
  end

  task automatic start_rec(input logic [31:0] base, input logic [15:0] tempo);
    cur_base  = base;
    exp_idx   = 0;
    iBaseAddr = base;
    iTempo    = tempo;
    iStart    = 1'b1;
    @(negedge CLK);
    iStart    = 1'b0;
  endtask

  task automatic note(input logic on, input logic [6:0] pitch, input logic [6:0] vol,
                      input logic [3:0] inst, input logic mel, input logic tick);
    iNoteValid  = 1'b1;
    iNoteOn     = on;
    iPitch      = pitch;
    iVolume     = vol;
    iInst       = inst;
    iMelody     = mel;
    iSampleTick = tick;
    @(negedge CLK);
    iNoteValid  = 1'b0;
    iSampleTick = 1'b0;
  endtask

  task automatic ticks(input int n);
    iSampleTick = 1'b1;
    repeat (n) @(negedge CLK);
    iSampleTick = 1'b0;
  endtask

  task automatic stop_rec();
    iStop = 1'b1;
    @(negedge CLK);
    iStop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (oBusy && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", 64'(oBusy), 64'd0);
    repeat (2) @(negedge CLK);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    Reset_n     = 1'b0;
    iSampleTick = 1'b0;
    iStart      = 1'b0;
    iStop       = 1'b0;
    iBaseAddr   = '0;
    iTempo      = '0;
    iNoteValid  = 1'b0;
    iNoteOn     = 1'b0;
    iPitch      = '0;
    iVolume     = '0;
    iInst       = '0;
    iMelody     = 1'b0;
    cur_base    = '0;
    exp_idx     = 0;
    repeat (3) @(negedge CLK);
    check("rst_write", 64'(oMemWrite), 64'd0);
    check("rst_addr", 64'(oMemAddress), 64'd0);
    check("rst_data", 64'(oMemWriteData), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_count", 64'(oWordCount), 64'd0);
    check("rst_ovf", 64'(oOverflow), 64'd0);
    Reset_n = 1'b1;
    @(negedge CLK);

    // Events in IDLE are ignored
    note(1'b1, 7'd10, 7'd50, 4'd1, 1'b0, 1'b0);
    stop_rec();
    check("idle_busy", 64'(oBusy), 64'd0);

    // Session 1: tempo 500, two overlapping notes, same-cycle off+tick
    start_rec(32'h1000_0000, 16'd500);
    check("start_busy", 64'(oBusy), 64'd1);
    note(1'b1, 7'd60, 7'd100, 4'd2, 1'b0, 1'b0);
    ticks(24000);
    note(1'b1, 7'd62, 7'd100, 4'd2, 1'b0, 1'b0);
    ticks(23999);
    push_exp(32'h02C8_F010);
    note(1'b0, 7'd60, 7'd0, 4'd0, 1'b0, 1'b1);
    repeat (5) @(negedge CLK);
    push_exp(32'h02C8_F808);
    note(1'b0, 7'd62, 7'd0, 4'd0, 1'b0, 1'b0);
    repeat (100) @(negedge CLK);
    push_exp(32'h0000_0200);
    stop_rec();
    wait_idle(2000);
    check("s1_count", 64'(oWordCount), 64'd3);
    check("s1_ovf", 64'(oOverflow), 64'd0);

    // Session 2: tempo 1, saturation, duplicate note-on, vol-0 off, stop latched in DIV
    start_rec(32'h0000_2000, 16'd1);
    note(1'b1, 7'd70, 7'd5, 4'd3, 1'b1, 1'b0);
    note(1'b1, 7'd70, 7'd9, 4'd4, 1'b0, 1'b0);
    ticks(1600);
    push_exp(note_word(1'b1, 4'd3, 7'd5, 7'd70, 1600, 1));
    note(1'b0, 7'd70, 7'd0, 4'd0, 1'b0, 1'b0);
    repeat (60) @(negedge CLK);
    note(1'b1, 7'd71, 7'd7, 4'd1, 1'b0, 1'b0);
    ticks(10);
    push_exp(note_word(1'b0, 4'd1, 7'd7, 7'd71, 10, 1));
    note(1'b1, 7'd71, 7'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    push_exp(32'h0000_0200);
    stop_rec();
    wait_idle(2000);
    check("s2_count", 64'(oWordCount), 64'd3);

    // Session 2b: tempo 0 saturates
    start_rec(32'h0000_3000, 16'd0);
    note(1'b1, 7'd5, 7'd1, 4'd0, 1'b0, 1'b0);
    ticks(3);
    push_exp(note_word(1'b0, 4'd0, 7'd1, 7'd5, 3, 0));
    note(1'b0, 7'd5, 7'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    push_exp(32'h0000_0200);
    stop_rec();
    wait_idle(2000);

    // Session 3: 9 note-ons, overflow, flush with a stalled first write
    start_rec(32'h0000_8000, 16'd2);
    for (int i = 0; i < 9; i++) begin
      note(1'b1, 7'(40 + i), 7'(20 + i), 4'(i), 1'(i & 1), 1'b0);
      if (i == 7) check("ovf_before_9th", 64'(oOverflow), 64'd0);
    end
    check("ovf_after_9th", 64'(oOverflow), 64'd1);
    ticks(100);
    for (int i = 0; i < 8; i++)
      push_exp(note_word(1'(i & 1), 4'(i), 7'(20 + i), 7'(40 + i), 100, 2));
    push_exp(32'h0000_0200);
    stall_cnt = 10;
    stop_rec();
    wait_idle(4000);
    check("s3_count", 64'(oWordCount), 64'd9);
    check("s3_ovf_sticky", 64'(oOverflow), 64'd1);

    // Session 4: unmatched note-off, then reset while in DIV
    start_rec(32'h0000_C000, 16'd4);
    check("start_clears_ovf", 64'(oOverflow), 64'd0);
    note(1'b1, 7'd50, 7'd30, 4'd5, 1'b0, 1'b0);
    ticks(10);
    note(1'b0, 7'd51, 7'd0, 4'd0, 1'b0, 1'b0);
    repeat (100) @(negedge CLK);
    check("unmatched_count", 64'(oWordCount), 64'd0);
    note(1'b0, 7'd50, 7'd0, 4'd0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    check("in_div_busy", 64'(oBusy), 64'd1);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_write", 64'(oMemWrite), 64'd0);
    check("mid_rst_busy", 64'(oBusy), 64'd0);
    check("mid_rst_addr", 64'(oMemAddress), 64'd0);
    check("mid_rst_data", 64'(oMemWriteData), 64'd0);
    check("mid_rst_count", 64'(oWordCount), 64'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    start_rec(32'h0001_0000, 16'd500);
    note(1'b1, 7'd60, 7'd100, 4'd2, 1'b0, 1'b0);
    ticks(3000);
    push_exp(note_word(1'b0, 4'd2, 7'd100, 7'd60, 3000, 500));
    note(1'b0, 7'd60, 7'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    push_exp(32'h0000_0200);
    stop_rec();
    wait_idle(2000);
    check("s4_count", 64'(oWordCount), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
